// File: rtl/axi_lite_arbiter_if.sv
// AXI4-lite bus bundle (32-bit address/data) shared by the arbiter and its slave.
// The master modport is the arbiter side, the slave modport the peripheral side.
interface axi_lite_arbiter_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-requester arbiter for one AXI4-lite master port, one single-beat transaction at a time.
// Round-robin by default; define AXI_ARB_FIXED_PRIO_EN for fixed priority (req0 wins).
module axi_lite_arbiter #(
  parameter logic [2:0] AXI_PROT  = 3'b000,
  parameter logic [3:0] AXI_WSTRB = 4'b1111
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req0_valid,
  input  logic                      req0_we,
  input  logic [31:0]               req0_addr,
  input  logic [31:0]               req0_wdata,
  output logic                      req0_done,
  output logic [31:0]               req0_rdata,
  output logic                      req0_err,
  input  logic                      req1_valid,
  input  logic                      req1_we,
  input  logic [31:0]               req1_addr,
  input  logic [31:0]               req1_wdata,
  output logic                      req1_done,
  output logic [31:0]               req1_rdata,
  output logic                      req1_err,
  axi_lite_arbiter_if.master        axi
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_ADDR = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]  state;
  logic        gnt;
  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        any_req;
  logic        aw_fin;
  logic        w_fin;

  function automatic logic resp_err(input logic [1:0] resp);
    return resp != 2'b00;
  endfunction

  assign axi.awprot = AXI_PROT;
  assign axi.arprot = AXI_PROT;
  assign axi.wstrb  = AXI_WSTRB;

  assign any_req = req0_valid | req1_valid;

`ifdef AXI_ARB_FIXED_PRIO_EN
  always_comb sel = ~req0_valid;
`else
  logic rr_ptr;

  // A lone requester wins outright; under contention the pointer picks.
  always_comb sel = (req0_valid & req1_valid) ? rr_ptr : req1_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= 1'b0;
    end else if (state == IDLE && any_req) begin
      rr_ptr <= ~sel;
    end
  end
`endif

  always_comb begin
    sel_we    = sel ? req1_we    : req0_we;
    sel_addr  = sel ? req1_addr  : req0_addr;
    sel_wdata = sel ? req1_wdata : req0_wdata;
  end

  // AW and W complete independently; a channel already accepted counts as finished.
  assign aw_fin = ~axi.awvalid | axi.awready;
  assign w_fin  = ~axi.wvalid  | axi.wready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      axi.awvalid <= 1'b0;
      axi.awaddr  <= '0;
      axi.wvalid  <= 1'b0;
      axi.wdata   <= '0;
      axi.bready  <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      axi.rready  <= 1'b0;
      req0_done   <= 1'b0;
      req0_rdata  <= '0;
      req0_err    <= 1'b0;
      req1_done   <= 1'b0;
      req1_rdata  <= '0;
      req1_err    <= 1'b0;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt <= sel;
            if (sel_we) begin
              axi.awvalid <= 1'b1;
              axi.wvalid  <= 1'b1;
              axi.awaddr  <= sel_addr;
              axi.wdata   <= sel_wdata;
              state       <= WR;
            end else begin
              axi.arvalid <= 1'b1;
              axi.araddr  <= sel_addr;
              state       <= RD_ADDR;
            end
          end
        end
        WR: begin
          if (axi.awready) axi.awvalid <= 1'b0;
          if (axi.wready)  axi.wvalid  <= 1'b0;
          if (aw_fin && w_fin) begin
            axi.bready <= 1'b1;
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            if (gnt) begin
              req1_done <= 1'b1;
              req1_err  <= resp_err(axi.bresp);
            end else begin
              req0_done <= 1'b1;
              req0_err  <= resp_err(axi.bresp);
            end
            state <= DONE;
          end
        end
        RD_ADDR: begin
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi.rvalid) begin
            axi.rready <= 1'b0;
            if (gnt) begin
              req1_done  <= 1'b1;
              req1_rdata <= axi.rdata;
              req1_err   <= resp_err(axi.rresp);
            end else begin
              req0_done  <= 1'b1;
              req0_rdata <= axi.rdata;
              req0_err   <= resp_err(axi.rresp);
            end
            state <= DONE;
          end
        end
        // Requests are deliberately not sampled here so the winner sees done first.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter and a reactive AXI4-lite slave with variable delays.
module tb_axi_lite_arbiter;
  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem   [16];
  logic [31:0] m_mem [16];
  logic [1:0]  resp_map [16];
  int          dly_aw, dly_w, dly_b, dly_ar, dly_r;
  bit          rand_dly, slave_en, rec_en;
  int          aw_hi, w_hi;
  logic [31:0] last_araddr;
  int          order_q[$];

  always #5 clk = ~clk;

  axi_lite_arbiter_if axi ();

  axi_lite_arbiter dut (
    .clk        (clk),
    .rstn       (rstn),
    .req0_valid (req_valid[0]),
    .req0_we    (req_we[0]),
    .req0_addr  (req_addr[0]),
    .req0_wdata (req_wdata[0]),
    .req0_done  (done0),
    .req0_rdata (rdata0),
    .req0_err   (err0),
    .req1_valid (req_valid[1]),
    .req1_we    (req_we[1]),
    .req1_addr  (req_addr[1]),
    .req1_wdata (req_wdata[1]),
    .req1_done  (done1),
    .req1_rdata (rdata1),
    .req1_err   (err1),
    .axi        (axi)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one request from requester n and wait (bounded) for its done pulse.
  task automatic do_req(input int n, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int drop_after,
                        output int lat, output logic [31:0] rd, output logic er);
    bit got;
    got = 0;
    lat = -1;
    rd  = '0;
    er  = 1'b0;
    @(negedge clk);
    req_valid[n] = 1'b1;
    req_we[n]    = we;
    req_addr[n]  = addr;
    req_wdata[n] = wdata;
    for (int c = 1; c <= 400 && !got; c++) begin
      @(negedge clk);
      if (c == drop_after) req_valid[n] = 1'b0;
      if ((n == 0) ? done0 : done1) begin
        got = 1;
        lat = c;
        rd  = (n == 0) ? rdata0 : rdata1;
        er  = (n == 0) ? err0 : err1;
      end
    end
    req_valid[n] = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL req%0d_timeout: got no done expected done within 400 cycles", n);
    end
  endtask

  // Reactive AXI4-lite slave: handshakes observed at posedge, outputs driven at negedge.
  initial begin
    bit          aw_got, w_got, ar_got, b_hs, r_hs;
    int          c_aw, c_w, c_b, c_ar, c_r;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
    c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
    s_awaddr = '0; s_wdata = '0; s_araddr = '0;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
        c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
      end else begin
        if (axi.awvalid) aw_hi++;
        if (axi.wvalid)  w_hi++;
        if (axi.awvalid && axi.awready) begin aw_got = 1; s_awaddr = axi.awaddr; end
        if (axi.wvalid && axi.wready)   begin w_got = 1;  s_wdata  = axi.wdata;  end
        if (axi.arvalid && axi.arready) begin
          ar_got = 1; s_araddr = axi.araddr; last_araddr = axi.araddr;
        end
        if (axi.bvalid && axi.bready) begin
          mem[s_awaddr[5:2]] = s_wdata;
          aw_got = 0; w_got = 0; b_hs = 1; c_aw = 0; c_w = 0; c_b = 0;
        end
        if (axi.rvalid && axi.rready) begin
          ar_got = 0; r_hs = 1; c_ar = 0; c_r = 0;
        end
        if ((b_hs || r_hs) && rand_dly) begin
          dly_aw = $urandom_range(0, 3); dly_w = $urandom_range(0, 3);
          dly_b  = $urandom_range(0, 3); dly_ar = $urandom_range(0, 3);
          dly_r  = $urandom_range(0, 3);
        end
      end
      @(negedge clk);
      if (slave_en) begin
        if (!rstn) begin
          axi.awready = 0; axi.wready = 0; axi.arready = 0;
          axi.bvalid = 0; axi.rvalid = 0; axi.bresp = 0; axi.rresp = 0;
        end else begin
          if (b_hs) begin axi.bvalid = 0; b_hs = 0; end
          if (r_hs) begin axi.rvalid = 0; r_hs = 0; end
          axi.awready = axi.awvalid && !aw_got && (c_aw >= dly_aw);
          if (axi.awvalid && !aw_got) c_aw++;
          axi.wready = axi.wvalid && !w_got && (c_w >= dly_w);
          if (axi.wvalid && !w_got) c_w++;
          axi.arready = axi.arvalid && !ar_got && (c_ar >= dly_ar);
          if (axi.arvalid && !ar_got) c_ar++;
          if (aw_got && w_got && !axi.bvalid) begin
            if (c_b >= dly_b) begin
              axi.bvalid = 1; axi.bresp = resp_map[s_awaddr[5:2]];
            end else c_b++;
          end
          if (ar_got && !axi.rvalid) begin
            if (c_r >= dly_r) begin
              axi.rvalid = 1; axi.rdata = mem[s_araddr[5:2]]; axi.rresp = resp_map[s_araddr[5:2]];
            end else c_r++;
          end
        end
      end
    end
  end

  // Transaction-level model: free -> busy (address/data phases) -> done -> free.
  initial begin
    int          ph;
    bit          own, rr, we, aw_ok, w_ok, a_ok;
    logic [31:0] ad, wd;
    logic [31:0] e_rd [2];
    logic        e_er [2];
    ph = 0; own = 0; rr = 0; we = 0; aw_ok = 0; w_ok = 0; a_ok = 0; ad = '0; wd = '0;
    e_rd[0] = '0; e_rd[1] = '0; e_er[0] = 0; e_er[1] = 0;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        ph = 0; rr = 0; e_rd[0] = '0; e_rd[1] = '0; e_er[0] = 0; e_er[1] = 0;
      end else begin
        case (ph)
          2: ph = 0;
          0: if (req_valid[0] || req_valid[1]) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
               own = req_valid[0] ? 1'b0 : 1'b1;
`else
               if (req_valid[0] && req_valid[1]) own = rr;
               else if (req_valid[0])            own = 0;
               else                              own = 1;
               rr = !own;
`endif
               we = req_we[own]; ad = req_addr[own]; wd = req_wdata[own];
               aw_ok = 0; w_ok = 0; a_ok = 0; ph = 1;
               if (we) m_mem[ad[5:2]] = wd;
             end
          default: begin
            if (we) begin
              if (aw_ok && w_ok && axi.bvalid) begin
                e_er[own] = resp_map[ad[5:2]] != 2'b00; ph = 2;
              end
              if (axi.awready) aw_ok = 1;
              if (axi.wready)  w_ok = 1;
            end else begin
              if (a_ok && axi.rvalid) begin
                e_rd[own] = m_mem[ad[5:2]]; e_er[own] = resp_map[ad[5:2]] != 2'b00; ph = 2;
              end
              if (axi.arready) a_ok = 1;
            end
          end
        endcase
      end
      #1;
      chk1("awvalid", axi.awvalid, ph == 1 && we && !aw_ok);
      chk1("wvalid",  axi.wvalid,  ph == 1 && we && !w_ok);
      chk1("bready",  axi.bready,  ph == 1 && we && aw_ok && w_ok);
      chk1("arvalid", axi.arvalid, ph == 1 && !we && !a_ok);
      chk1("rready",  axi.rready,  ph == 1 && !we && a_ok);
      chk1("done0",   done0,       ph == 2 && own == 0);
      chk1("done1",   done1,       ph == 2 && own == 1);
      chk("rdata0",   rdata0,      e_rd[0]);
      chk("rdata1",   rdata1,      e_rd[1]);
      chk1("err0",    err0,        e_er[0]);
      chk1("err1",    err1,        e_er[1]);
      chk("prot",     {26'd0, axi.awprot, axi.arprot}, 32'd0);
      chk("wstrb",    {28'd0, axi.wstrb}, 32'hF);
      if (ph == 1 && we && !aw_ok) chk("awaddr", axi.awaddr, ad);
      if (ph == 1 && we && !w_ok)  chk("wdata",  axi.wdata,  wd);
      if (ph == 1 && !we && !a_ok) chk("araddr", axi.araddr, ad);
      if (rec_en && done0) order_q.push_back(0);
      if (rec_en && done1) order_q.push_back(1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400us");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    bit          seen;
    int          exp_order [8];
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'hC0DE_0000 | 32'(i);
      resp_map[i] = 2'b00;
    end
    mem[0] = 32'h0000_0041;
    resp_map[5] = 2'b10; resp_map[9] = 2'b11; resp_map[13] = 2'b10;
    for (int i = 0; i < 16; i++) m_mem[i] = mem[i];
    for (int n = 0; n < 2; n++) begin
      req_valid[n] = 0; req_we[n] = 0; req_addr[n] = '0; req_wdata[n] = '0;
    end
    slave_en = 0; rand_dly = 0; rec_en = 0; last_araddr = 32'hFFFF_FFFF;
    dly_aw = 0; dly_w = 0; dly_b = 0; dly_ar = 0; dly_r = 0; aw_hi = 0; w_hi = 0;
    axi.awready = 1; axi.wready = 1; axi.arready = 1;
    axi.bvalid = 0; axi.rvalid = 0; axi.bresp = 0; axi.rresp = 0; axi.rdata = '0;
    rstn = 0;
    repeat (3) @(negedge clk);
    chk1("rst_awvalid", axi.awvalid, 0);
    chk1("rst_wvalid",  axi.wvalid,  0);
    chk1("rst_bready",  axi.bready,  0);
    chk1("rst_arvalid", axi.arvalid, 0);
    chk1("rst_rready",  axi.rready,  0);
    chk1("rst_done0",   done0, 0);
    chk1("rst_done1",   done1, 0);
    chk("rst_rdata0",   rdata0, 32'h0);
    chk("rst_rdata1",   rdata1, 32'h0);
    chk("rst_awaddr",   axi.awaddr, 32'h0);
    chk("rst_araddr",   axi.araddr, 32'h0);
    chk("rst_wdata",    axi.wdata, 32'h0);
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    slave_en = 1;
    @(negedge clk);
    rstn = 1;
    @(negedge clk);

    do_req(0, 1'b0, 32'h0, 32'h0, 0, lat, rd, er);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_rdata",   rd, 32'h0000_0041);
    chk1("rd_err",    er, 1'b0);
    chk("rd_araddr",  last_araddr, 32'h0);

    dly_w = 2; aw_hi = 0; w_hi = 0;
    do_req(1, 1'b1, 32'h4, 32'h55, 0, lat, rd, er);
    dly_w = 0;
    chk("wr_latency",  32'(lat), 32'd5);
    chk("wr_aw_cycles", 32'(aw_hi), 32'd1);
    chk("wr_w_cycles",  32'(w_hi), 32'd3);
    chk1("wr_err",     er, 1'b0);
    chk("wr_mem",      mem[1], 32'h55);

    do_req(0, 1'b1, 32'h14, 32'hDEAD_BEEF, 0, lat, rd, er);
    chk1("slverr_err", er, 1'b1);
    chk("slverr_latency", 32'(lat), 32'd3);
    do_req(0, 1'b1, 32'h8, 32'h1234, 0, lat, rd, er);
    chk1("okay_err", er, 1'b0);
    chk("wr_keeps_rdata", rdata0, 32'h0000_0041);

    do_req(0, 1'b0, 32'hC, 32'h0, 1, lat, rd, er);
    chk("drop_latency", 32'(lat), 32'd3);
    chk("drop_rdata",   rd, 32'hC0DE_0003);

    @(negedge clk); rstn = 0;
    @(negedge clk); rstn = 1;
    rec_en = 1;
    fork
      begin
        int l; logic [31:0] r; logic e;
        for (int i = 0; i < 4; i++) do_req(0, 1'b0, 32'(i * 4), 32'h0, 0, l, r, e);
      end
      begin
        int l; logic [31:0] r; logic e;
        for (int i = 0; i < 4; i++) do_req(1, 1'b0, 32'(8 + i * 4), 32'h0, 0, l, r, e);
      end
    join
    rec_en = 0;
`ifdef AXI_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    chk("order_len", 32'(order_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < order_q.size()) chk($sformatf("order_%0d", i), 32'(order_q[i]), 32'(exp_order[i]));

    dly_ar = 4;
    @(negedge clk);
    req_valid[1] = 1; req_we[1] = 0; req_addr[1] = 32'h4;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (axi.arvalid) seen = 1;
    end
    chk1("mid_arvalid_seen", seen, 1'b1);
    rstn = 0;
    #1;
    chk1("mid_arvalid_drop", axi.arvalid, 1'b0);
    req_valid[1] = 0;
    repeat (2) @(negedge clk);
    rstn = 1; dly_ar = 0;
    do_req(1, 1'b0, 32'h4, 32'h0, 0, lat, rd, er);
    chk("post_rst_rdata", rd, 32'h55);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk1("post_rst_err", er, 1'b0);

    rand_dly = 1;
    fork
      begin
        int l; logic [31:0] r; logic e;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          do_req(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom, 0, l, r, e);
        end
      end
      begin
        int l; logic [31:0] r; logic e;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          do_req(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom, 0, l, r, e);
        end
      end
    join
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
